clock_div_prog: RTL and testbench

CLOCK_DIV_PROG -- requirements
Module: clock_div_prog

---
 rtl/clock_div_pkg.sv | 15 +
 rtl/clock_div_phase_ctr.sv | 36 +++
 rtl/clock_div_prog.sv | 139 +++++++++++++
 tb/tb_clock_div_prog.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_div_pkg.sv
// Shared constants for the programmable clock divider: default widths,
// the smallest legal divisor and the divisor used out of reset.
package clock_div_pkg;

   localparam int unsigned DEF_WIDTH     = 16;
   localparam int unsigned MIN_DIV       = 2;
   localparam int unsigned DEF_RESET_DIV = 2;

   // IDLE means no period has started yet since reset
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } run_state_t;

endpackage

// File: rtl/clock_div_phase_ctr.sv
// Phase counter for the divider: counts 0..limit-1 while advancing,
// wraps to 0 after limit-1 and jumps to 0 on a restart.
module clock_div_phase_ctr
   import clock_div_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             advance,
   input  logic             restart,
   input  logic [WIDTH-1:0] limit,
   output logic [WIDTH-1:0] phase
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic last_phase;

   assign last_phase = (phase == (limit - ONE));

   always_ff @(posedge clk_in) begin
      if (rst) begin
         phase <= '0;
      end else if (restart) begin
         phase <= '0;
      end else if (advance) begin
         if (last_phase) begin
            phase <= '0;
         end else begin
            phase <= phase + ONE;
         end
      end
   end

endmodule

// File: rtl/clock_div_prog.sv
// Programmable clock divider with a shadowed divisor that is applied only
// at period boundaries, plus registered clk_out and period-start tick.
module clock_div_prog
   import clock_div_pkg::*;
#(
   parameter int unsigned WIDTH     = DEF_WIDTH,
   parameter int unsigned RESET_DIV = DEF_RESET_DIV
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             en,
   input  logic             sync,
   input  logic [WIDTH-1:0] div_val,
   input  logic             div_load,
   output logic             clk_out,
   output logic             tick,
   output logic [WIDTH-1:0] div_cur,
   output logic             pending,
   output logic             err
);

   localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
   localparam logic [WIDTH-1:0] MIN_VAL   = WIDTH'(MIN_DIV);
   localparam logic [WIDTH-1:0] RESET_VAL = WIDTH'(RESET_DIV);

   run_state_t       state;
   run_state_t       next_state;
   logic             advance;
   logic             restart;
   logic             wrap;
   logic             boundary;
   logic             load_ok;
   logic             load_bad;
   logic [WIDTH-1:0] phase;
   logic [WIDTH-1:0] phase_next;
   logic [WIDTH-1:0] shadow;
   logic [WIDTH-1:0] div_next;
   logic [WIDTH-1:0] high_limit;
   logic             clk_next;

   clock_div_phase_ctr #(
      .WIDTH(WIDTH)
   ) u_phase_ctr (
      .clk_in (clk_in),
      .rst    (rst),
      .advance(advance),
      .restart(restart),
      .limit  (div_cur),
      .phase  (phase)
   );

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // The first enabled (or synced) cycle after reset starts a fresh period
   // at phase 0 instead of stepping past it, so the first period gets a tick.
   always_comb begin
      next_state = state;
      advance    = 1'b0;
      restart    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (sync || en) begin
               restart    = 1'b1;
               next_state = ST_RUN;
            end
         end
         ST_RUN: begin
            restart = sync;
            advance = en && !sync;
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   assign wrap     = advance && (phase == (div_cur - ONE));
   assign boundary = restart || wrap;
   assign load_ok  = div_load && (div_val >= MIN_VAL);
   assign load_bad = div_load && (div_val < MIN_VAL);

   // A load arriving on the boundary itself beats a value already waiting
   always_comb begin
      div_next = div_cur;
      if (boundary) begin
         if (load_ok) begin
            div_next = div_val;
         end else if (pending) begin
            div_next = shadow;
         end
      end
   end

   // N - floor(N/2) never exceeds N, so it cannot overflow WIDTH bits
   always_comb begin
      phase_next = phase;
      if (boundary) begin
         phase_next = '0;
      end else if (advance) begin
         phase_next = phase + ONE;
      end
      high_limit = div_next - (div_next >> 1);
      clk_next   = clk_out;
      if (advance || restart) begin
         clk_next = (phase_next < high_limit);
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         div_cur <= RESET_VAL;
         shadow  <= RESET_VAL;
         pending <= 1'b0;
         err     <= 1'b0;
         tick    <= 1'b0;
         clk_out <= 1'b0;
      end else begin
         div_cur <= div_next;
         if (load_ok) begin
            shadow <= div_val;
         end
         if (boundary) begin
            pending <= 1'b0;
         end else if (load_ok) begin
            pending <= 1'b1;
         end
         err     <= load_bad;
         tick    <= boundary;
         clk_out <= clk_next;
      end
   end

endmodule

// File: tb/tb_clock_div_prog.sv
// Scenario bench for clock_div_prog: each task drives a cycle table, queues
// the expected outputs and compares them one cycle later.
module tb_clock_div_prog;

   typedef struct packed {
      logic        rst;
      logic        en;
      logic        sync;
      logic        ld;
      logic [15:0] val;
      logic        clk_out;
      logic        tick;
      logic        pend;
      logic        err;
      logic [15:0] div;
   } row_t;

   logic        clk_in;
   logic        rst;
   logic        en;
   logic        sync;
   logic [15:0] div_val;
   logic        div_load;
   logic        clk_out;
   logic        tick;
   logic [15:0] div_cur;
   logic        pending;
   logic        err;

   int   checks;
   int   passed;
   row_t exp_q[$];

   clock_div_prog #(
      .WIDTH    (16),
      .RESET_DIV(2)
   ) dut (
      .clk_in  (clk_in),
      .rst     (rst),
      .en      (en),
      .sync    (sync),
      .div_val (div_val),
      .div_load(div_load),
      .clk_out (clk_out),
      .tick    (tick),
      .div_cur (div_cur),
      .pending (pending),
      .err     (err)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   function automatic row_t r(input logic r_rst, input logic r_en, input logic r_sync,
                              input logic r_ld, input int r_val, input logic e_clk,
                              input logic e_tick, input logic e_pend, input logic e_err,
                              input int e_div);
      row_t x;
      x.rst     = r_rst;
      x.en      = r_en;
      x.sync    = r_sync;
      x.ld      = r_ld;
      x.val     = 16'(r_val);
      x.clk_out = e_clk;
      x.tick    = e_tick;
      x.pend    = e_pend;
      x.err     = e_err;
      x.div     = 16'(e_div);
      return x;
   endfunction

   task automatic drive(input row_t x);
      rst      = x.rst;
      en       = x.en;
      sync     = x.sync;
      div_load = x.ld;
      div_val  = x.val;
   endtask

   task automatic test_reset();
      row_t rows[$];
      row_t want;
      rows.push_back(r(1, 1, 0, 0, 0, 0, 0, 0, 0, 2));
      rows.push_back(r(1, 1, 0, 1, 9, 0, 0, 0, 0, 2));
      foreach (rows[i]) begin
         drive(rows[i]);
         exp_q.push_back(rows[i]);
         @(posedge clk_in);
         #1;
         want = exp_q.pop_front();
         checks++;
         if ({clk_out, tick, pending, err, div_cur} !== {want.clk_out, want.tick, want.pend, want.err, want.div})
            $display("[TB] FAIL reset[%0d]: got clk=%b tick=%b pend=%b err=%b div=%0d, want clk=%b tick=%b pend=%b err=%b div=%0d",
                     i, clk_out, tick, pending, err, div_cur, want.clk_out, want.tick, want.pend, want.err, want.div);
         else
            passed++;
      end
   endtask

   task automatic test_default_div();
      row_t rows[$];
      row_t want;
      for (int k = 0; k < 3; k++) begin
         rows.push_back(r(0, 1, 0, 0, 0, 1, 1, 0, 0, 2));
         rows.push_back(r(0, 1, 0, 0, 0, 0, 0, 0, 0, 2));
      end
      foreach (rows[i]) begin
         drive(rows[i]);
         exp_q.push_back(rows[i]);
         @(posedge clk_in);
         #1;
         want = exp_q.pop_front();
         checks++;
         if ({clk_out, tick, pending, err, div_cur} !== {want.clk_out, want.tick, want.pend, want.err, want.div})
            $display("[TB] FAIL default_div[%0d]: got clk=%b tick=%b pend=%b err=%b div=%0d, want clk=%b tick=%b pend=%b err=%b div=%0d",
                     i, clk_out, tick, pending, err, div_cur, want.clk_out, want.tick, want.pend, want.err, want.div);
         else
            passed++;
      end
   endtask

   task automatic test_load_five();
      row_t rows[$];
      row_t want;
      rows.push_back(r(0, 1, 0, 0, 0, 1, 1, 0, 0, 2));
      rows.push_back(r(0, 1, 0, 1, 5, 0, 0, 1, 0, 2));
      rows.push_back(r(0, 1, 0, 0, 0, 1, 1, 0, 0, 5));
      rows.push_back(r(0, 1, 0, 0, 0, 1, 0, 0, 0, 5));
      rows.push_back(r(0, 1, 0, 0, 0, 1, 0, 0, 0, 5));
      rows.push_back(r(0, 1, 0, 0, 0, 0, 0, 0, 0, 5));
      rows.push_back(r(0, 1, 0, 0, 0, 0, 0, 0, 0, 5));
      rows.push_back(r(0, 1, 0, 0, 0, 1, 1, 0, 0, 5));
      foreach (rows[i]) begin
         drive(rows[i]);
         exp_q.push_back(rows[i]);
         @(posedge clk_in);
         #1;
         want = exp_q.pop_front();
         checks++;
         if ({clk_out, tick, pending, err, div_cur} !== {want.clk_out, want.tick, want.pend, want.err, want.div})
            $display("[TB] FAIL load_five[%0d]: got clk=%b tick=%b pend=%b err=%b div=%0d, want clk=%b tick=%b pend=%b err=%b div=%0d",
                     i, clk_out, tick, pending, err, div_cur, want.clk_out, want.tick, want.pend, want.err, want.div);
         else
            passed++;
      end
   endtask

   task automatic test_bad_load();
      row_t rows[$];
      row_t want;
      rows.push_back(r(0, 1, 0, 1, 0, 1, 0, 0, 1, 5));
      rows.push_back(r(0, 1, 0, 0, 0, 1, 0, 0, 0, 5));
      rows.push_back(r(0, 1, 0, 1, 1, 0, 0, 0, 1, 5));
      rows.push_back(r(0, 1, 0, 0, 0, 0, 0, 0, 0, 5));
      rows.push_back(r(0, 1, 0, 0, 0, 1, 1, 0, 0, 5));
      foreach (rows[i]) begin
         drive(rows[i]);
         exp_q.push_back(rows[i]);
         @(posedge clk_in);
         #1;
         want = exp_q.pop_front();
         checks++;
         if ({clk_out, tick, pending, err, div_cur} !== {want.clk_out, want.tick, want.pend, want.err, want.div})
            $display("[TB] FAIL bad_load[%0d]: got clk=%b tick=%b pend=%b err=%b div=%0d, want clk=%b tick=%b pend=%b err=%b div=%0d",
                     i, clk_out, tick, pending, err, div_cur, want.clk_out, want.tick, want.pend, want.err, want.div);
         else
            passed++;
      end
   endtask

   task automatic test_en_hold();
      row_t rows[$];
      row_t want;
      rows.push_back(r(0, 1, 0, 1, 6, 1, 0, 1, 0, 5));
      rows.push_back(r(0, 1, 0, 1, 4, 1, 0, 1, 0, 5));
      rows.push_back(r(0, 1, 0, 0, 0, 0, 0, 1, 0, 5));
      rows.push_back(r(0, 1, 0, 0, 0, 0, 0, 1, 0, 5));
      rows.push_back(r(0, 1, 0, 0, 0, 1, 1, 0, 0, 4));
      rows.push_back(r(0, 1, 0, 0, 0, 1, 0, 0, 0, 4));
      rows.push_back(r(0, 1, 0, 0, 0, 0, 0, 0, 0, 4));
      rows.push_back(r(0, 0, 0, 0, 0, 0, 0, 0, 0, 4));
      rows.push_back(r(0, 0, 0, 0, 0, 0, 0, 0, 0, 4));
      rows.push_back(r(0, 0, 0, 0, 0, 0, 0, 0, 0, 4));
      rows.push_back(r(0, 1, 0, 0, 0, 0, 0, 0, 0, 4));
      rows.push_back(r(0, 1, 0, 0, 0, 1, 1, 0, 0, 4));
      foreach (rows[i]) begin
         drive(rows[i]);
         exp_q.push_back(rows[i]);
         @(posedge clk_in);
         #1;
         want = exp_q.pop_front();
         checks++;
         if ({clk_out, tick, pending, err, div_cur} !== {want.clk_out, want.tick, want.pend, want.err, want.div})
            $display("[TB] FAIL en_hold[%0d]: got clk=%b tick=%b pend=%b err=%b div=%0d, want clk=%b tick=%b pend=%b err=%b div=%0d",
                     i, clk_out, tick, pending, err, div_cur, want.clk_out, want.tick, want.pend, want.err, want.div);
         else
            passed++;
      end
   endtask

   task automatic test_sync();
      row_t rows[$];
      row_t want;
      rows.push_back(r(0, 1, 0, 1, 7, 1, 0, 1, 0, 4));
      rows.push_back(r(0, 1, 0, 0, 0, 0, 0, 1, 0, 4));
      rows.push_back(r(0, 1, 0, 0, 0, 0, 0, 1, 0, 4));
      rows.push_back(r(0, 1, 0, 0, 0, 1, 1, 0, 0, 7));
      rows.push_back(r(0, 1, 0, 0, 0, 1, 0, 0, 0, 7));
      rows.push_back(r(0, 1, 0, 1, 3, 1, 0, 1, 0, 7));
      rows.push_back(r(0, 1, 0, 0, 0, 1, 0, 1, 0, 7));
      rows.push_back(r(0, 1, 1, 0, 0, 1, 1, 0, 0, 3));
      rows.push_back(r(0, 1, 0, 0, 0, 1, 0, 0, 0, 3));
      rows.push_back(r(0, 1, 0, 0, 0, 0, 0, 0, 0, 3));
      rows.push_back(r(0, 1, 0, 0, 0, 1, 1, 0, 0, 3));
      rows.push_back(r(0, 0, 0, 0, 0, 1, 0, 0, 0, 3));
      rows.push_back(r(0, 0, 1, 0, 0, 1, 1, 0, 0, 3));
      rows.push_back(r(0, 1, 0, 0, 0, 1, 0, 0, 0, 3));
      foreach (rows[i]) begin
         drive(rows[i]);
         exp_q.push_back(rows[i]);
         @(posedge clk_in);
         #1;
         want = exp_q.pop_front();
         checks++;
         if ({clk_out, tick, pending, err, div_cur} !== {want.clk_out, want.tick, want.pend, want.err, want.div})
            $display("[TB] FAIL sync[%0d]: got clk=%b tick=%b pend=%b err=%b div=%0d, want clk=%b tick=%b pend=%b err=%b div=%0d",
                     i, clk_out, tick, pending, err, div_cur, want.clk_out, want.tick, want.pend, want.err, want.div);
         else
            passed++;
      end
   endtask

   task automatic test_back_to_back();
      row_t rows[$];
      row_t want;
      rows.push_back(r(0, 1, 0, 0, 0, 0, 0, 0, 0, 3));
      rows.push_back(r(0, 1, 0, 1, 2, 1, 1, 0, 0, 2));
      rows.push_back(r(0, 1, 0, 0, 0, 0, 0, 0, 0, 2));
      rows.push_back(r(0, 1, 0, 0, 0, 1, 1, 0, 0, 2));
      foreach (rows[i]) begin
         drive(rows[i]);
         exp_q.push_back(rows[i]);
         @(posedge clk_in);
         #1;
         want = exp_q.pop_front();
         checks++;
         if ({clk_out, tick, pending, err, div_cur} !== {want.clk_out, want.tick, want.pend, want.err, want.div})
            $display("[TB] FAIL back_to_back[%0d]: got clk=%b tick=%b pend=%b err=%b div=%0d, want clk=%b tick=%b pend=%b err=%b div=%0d",
                     i, clk_out, tick, pending, err, div_cur, want.clk_out, want.tick, want.pend, want.err, want.div);
         else
            passed++;
      end
   endtask

   task automatic test_reset_pending();
      row_t rows[$];
      row_t want;
      rows.push_back(r(0, 1, 0, 1, 9, 0, 0, 1, 0, 2));
      rows.push_back(r(1, 1, 0, 0, 0, 0, 0, 0, 0, 2));
      rows.push_back(r(0, 1, 0, 0, 0, 1, 1, 0, 0, 2));
      rows.push_back(r(0, 1, 0, 0, 0, 0, 0, 0, 0, 2));
      rows.push_back(r(0, 1, 0, 0, 0, 1, 1, 0, 0, 2));
      foreach (rows[i]) begin
         drive(rows[i]);
         exp_q.push_back(rows[i]);
         @(posedge clk_in);
         #1;
         want = exp_q.pop_front();
         checks++;
         if ({clk_out, tick, pending, err, div_cur} !== {want.clk_out, want.tick, want.pend, want.err, want.div})
            $display("[TB] FAIL reset_pending[%0d]: got clk=%b tick=%b pend=%b err=%b div=%0d, want clk=%b tick=%b pend=%b err=%b div=%0d",
                     i, clk_out, tick, pending, err, div_cur, want.clk_out, want.tick, want.pend, want.err, want.div);
         else
            passed++;
      end
   endtask

   initial begin
      checks   = 0;
      passed   = 0;
      rst      = 1'b1;
      en       = 1'b0;
      sync     = 1'b0;
      div_val  = '0;
      div_load = 1'b0;
      test_reset();
      test_default_div();
      test_load_five();
      test_bad_load();
      test_en_hold();
      test_sync();
      test_back_to_back();
      test_reset_pending();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
